// File: rtl/dmem_responder.sv
// Word-addressed data-memory slave for the core's data bus, one request at a time.
// Latency: access WAIT_STATES cycles after acceptance; ready pulses for one cycle after that.
// Backpressure: none queued; req is only sampled in IDLE and must be re-presented after busy drops.
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   req, we, addr,       request strobe and its captured command fields
//   wdata, byte_en       (byte_en selects write lanes, ignored on reads)
//   ready                one-cycle response strobe
//   rdata                read data, held until the next read completes
//   busy                 high while a request is in flight (WAIT or RESP)
module dmem_responder #(
   parameter int    ADDR_WIDTH  = 6,
   parameter int    DATA_WIDTH  = 32,
   parameter int    WAIT_STATES = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   output logic                    ready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    busy
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NB-1:0]         be_q;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   logic                  accept;
   logic                  access;
   logic                  acc_we;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic [NB-1:0]         acc_be;

   // reset_n is folded in so that a zero-wait configuration cannot commit a
   // write from a req presented while reset is still held.
   assign accept = reset_n && (state_q == S_IDLE) && req;

   // With no wait states the access happens on the acceptance edge itself,
   // so it must use the live request fields rather than the latched copies.
   generate
      if (WAIT_STATES == 0) begin : g_direct
         assign access    = accept;
         assign acc_we    = we;
         assign acc_addr  = addr;
         assign acc_wdata = wdata;
         assign acc_be    = byte_en;
      end else begin : g_latched
         assign access    = (state_q == S_WAIT) && (cnt_q == CW'(1));
         assign acc_we    = we_q;
         assign acc_addr  = addr_q;
         assign acc_wdata = wdata_q;
         assign acc_be    = be_q;
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req) state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt_q == CW'(1)) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded straight from the state register.
   always_comb begin
      ready = (state_q == S_RESP);
      busy  = (state_q != S_IDLE);
   end

   // Request capture, wait counter and read-data register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata   <= '0;
      end else begin
         if (accept) begin
            cnt_q   <= CNT_LOAD;
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= byte_en;
         end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            // Counter ends at zero on the access edge and is only reloaded from IDLE.
            cnt_q <= cnt_q - CW'(1);
         end
         if (access && !acc_we) begin
            rdata <= mem[acc_addr];
         end
      end
   end

   // Array is deliberately outside reset: contents survive reset_n.
   always_ff @(posedge clk) begin
      if (access && acc_we) begin
         for (int i = 0; i < NB; i++) begin
            if (acc_be[i]) mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int  AW  = 6;
   localparam int  DW  = 32;
   localparam int  WS  = 2;
   localparam time TCK = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;

   // main instance, WAIT_STATES = 2
   logic          req = 1'b0, we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [3:0]    byte_en = '0;
   logic          ready, busy;
   logic [DW-1:0] rdata;

   // second instance, WAIT_STATES = 0
   logic          req0 = 1'b0, we0 = 1'b0;
   logic [AW-1:0] addr0 = '0;
   logic [DW-1:0] wdata0 = '0;
   logic [3:0]    be0 = '0;
   logic          ready0, busy0;
   logic [DW-1:0] rdata0;

   always #(TCK/2) clk = ~clk;

   dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS), .INIT_FILE("")) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .byte_en(byte_en), .ready(ready), .rdata(rdata), .busy(busy));

   dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
      .clk(clk), .reset_n(reset_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .byte_en(be0), .ready(ready0), .rdata(rdata0), .busy(busy0));

   typedef struct {
      bit          rd;
      logic [31:0] data;
      time         t;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ref_mem [64];
   logic [31:0] model_rdata = '0;
   time         last_issue_t;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: ready=1 with nothing outstanding at %0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("resp_time", 32'($time), 32'(e.t));
            check("busy_in_resp", {31'd0, busy}, 32'd1);
            check(e.rd ? "read_data" : "rdata_hold_on_write", rdata, e.data);
         end
      end
   end

   // Called at a falling edge; returns at the first falling edge where the DUT is idle.
   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy stuck at %b", busy);
            return;
         end
      end
   endtask

   // Issue one request; with hold=1 req stays high so the DUT re-accepts on its own.
   task automatic issue(input bit w, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] be_v, input bit hold);
      exp_t e;
      wait_idle();
      req = 1'b1; we = w; addr = a; wdata = d; byte_en = be_v;
      if (w) begin
         for (int i = 0; i < 4; i++)
            if (be_v[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
         e.rd = 1'b0;
         e.data = model_rdata;
      end else begin
         model_rdata = ref_mem[a];
         e.rd = 1'b1;
         e.data = ref_mem[a];
      end
      // accepted on the next rising edge, then WS wait cycles, then the ready cycle
      e.t = $time + (1 + WS) * TCK;
      sb_q.push_back(e);
      last_issue_t = $time;
      @(negedge clk);
      if (!hold) req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses missing", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      time prev_t;

      // Reset held while req toggles: everything stays quiet.
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         req = n[0]; we = 1'b1; addr = 6'd1; wdata = 32'hFFFF_FFFF; byte_en = 4'hF;
         req0 = n[0]; we0 = 1'b1; wdata0 = 32'hFFFF_FFFF; be0 = 4'hF;
         check("rst_ready", {31'd0, ready}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_rdata", rdata, 32'd0);
         check("rst_ready0", {31'd0, ready0}, 32'd0);
         check("rst_rdata0", rdata0, 32'd0);
      end
      @(negedge clk);
      req = 1'b0; req0 = 1'b0;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);

      // Write then read back.
      issue(1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
      issue(1'b0, 6'd5, '0, 4'h0, 1'b0);

      // Byte lanes 0 and 2 only.
      issue(1'b1, 6'd7, 32'h1122_3344, 4'hF, 1'b0);
      issue(1'b1, 6'd7, 32'hAABB_CCDD, 4'b0101, 1'b0);
      issue(1'b0, 6'd7, '0, 4'hF, 1'b0);

      // Address extremes must not alias.
      issue(1'b1, 6'd63, 32'hFFFF_FFFF, 4'hF, 1'b0);
      issue(1'b1, 6'd0, 32'h0000_0001, 4'hF, 1'b0);
      issue(1'b0, 6'd63, '0, 4'h0, 1'b0);
      issue(1'b0, 6'd0, '0, 4'h0, 1'b0);

      // Fill the whole array so random reads are always defined.
      for (int a = 0; a < 64; a++) issue(1'b1, 6'(a), $urandom, 4'hF, 1'b0);

      // Random mix, including zero byte enables.
      for (int n = 0; n < 150; n++)
         issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
               4'($urandom_range(0, 15)), 1'b0);

      // req held high: acceptance only once per 4 cycles.
      drain();
      issue(1'b0, 6'd5, '0, 4'h0, 1'b1);
      prev_t = last_issue_t;
      for (int n = 0; n < 5; n++) begin
         issue(1'b0, 6'($urandom_range(0, 63)), '0, 4'h0, n < 4);
         check("hold_period", 32'(last_issue_t - prev_t), 32'(4 * TCK));
         prev_t = last_issue_t;
      end

      // Reset during WAIT drops the uncommitted write.
      drain();
      issue(1'b1, 6'd3, 32'h0, 4'hF, 1'b0);
      drain();
      wait_idle();
      req = 1'b1; we = 1'b1; addr = 6'd3; wdata = 32'h1234_5678; byte_en = 4'hF;
      @(negedge clk);
      req = 1'b0;
      check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      model_rdata = '0;
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_ready", {31'd0, ready}, 32'd0);
         check("mid_rst_busy", {31'd0, busy}, 32'd0);
         check("mid_rst_rdata", rdata, 32'd0);
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      issue(1'b0, 6'd3, '0, 4'h0, 1'b0);
      drain();

      // Zero-wait instance: req held, ready every other cycle, read-after-write.
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 6'd9; wdata0 = 32'hCAFE_F00D; be0 = 4'hF;
      @(negedge clk);
      check("ws0_ready_wr", {31'd0, ready0}, 32'd1);
      we0 = 1'b0;
      @(negedge clk);
      check("ws0_gap", {30'd0, ready0, busy0}, 32'd0);
      @(negedge clk);
      check("ws0_ready_rd", {31'd0, ready0}, 32'd1);
      check("ws0_rdata", rdata0, 32'hCAFE_F00D);
      @(negedge clk);
      check("ws0_gap2", {31'd0, ready0}, 32'd0);
      @(negedge clk);
      check("ws0_ready_rd2", {31'd0, ready0}, 32'd1);
      check("ws0_rdata2", rdata0, 32'hCAFE_F00D);
      req0 = 1'b0;
      @(negedge clk);
      check("ws0_idle", {30'd0, ready0, busy0}, 32'd0);
      @(negedge clk);
      check("ws0_no_req", {31'd0, ready0}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #(TCK * 20000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
